// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipeline register chain.
package pipe_reg_chain_pkg;

  // RV32 ADDI x0,x0,0: the canonical no-op presented on an empty output
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One chain stage: valid bit with async reset plus an unreset data register.
module pipe_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             valid_nxt_c,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;

  // Advancing overwrites the held item; a flushed item that cannot advance is dropped in place.
  always_comb begin
    valid_d = valid_q;
    if (adv_i) begin
      valid_d = up_valid_i;
    end else if (flush_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (adv_i) begin
      data_q <= up_data_i;
    end
  end

  assign valid_nxt_c = valid_d;
  assign valid_o     = valid_q;
  assign data_o      = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Valid/ready register chain with bubble collapsing, per-stage flush and occupancy count.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] NOP_VALUE = NOP_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  input  logic [DEPTH-1:0]             flush_mask,
  output logic [clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int unsigned      OCC_W = clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_nxt_c;
  logic [DEPTH-1:0] adv_c;
  logic [WIDTH-1:0] data [DEPTH];
  logic [OCC_W-1:0] occ_d;
  logic [OCC_W-1:0] occ_q;

  // A stage advances unless it and every stage downstream are full with out_ready low.
  always_comb begin
    logic full;
    full  = 1'b1;
    adv_c = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      full     = full & valid[i];
      adv_c[i] = out_ready | ~full;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;

    if (g == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
    end else begin : g_body
      assign up_valid = valid[g-1] & ~flush_mask[g-1];
      assign up_data  = data[g-1];
    end

    pipe_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv_i      (adv_c[g]),
      .flush_i    (flush_mask[g]),
      .up_valid_i (up_valid),
      .up_data_i  (up_data),
      .valid_nxt_c(valid_nxt_c[g]),
      .valid_o    (valid[g]),
      .data_o     (data[g])
    );
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_d = occ_d + OCC_W'(valid_nxt_c[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign in_ready  = adv_c[0];
  assign out_valid = valid[DEPTH-1] & ~flush_mask[DEPTH-1];
  assign out_data  = valid[DEPTH-1] ? data[DEPTH-1] : NOP_W;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Self-checking bench for pipe_reg_chain (WIDTH=8, DEPTH=3, NOP=8'h13).
module tb_pipe_reg_chain;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] flush_mask;
  logic [1:0] occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_reg_chain #(
    .WIDTH    (8),
    .DEPTH    (3),
    .NOP_VALUE(32'h0000_0013)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush_mask(flush_mask),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic [2:0] fm);
    in_valid = v; in_data = d; out_ready = r; flush_mask = fm;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 3'b000);
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_checks++; if (out_data !== 8'h13) begin n_fail++; $display("FAIL reset_out_data got %h exp 13", out_data); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    edge_step();
  endtask

  task automatic test_stream();
    logic       ev;
    logic [7:0] ed;
    for (int c = 0; c < 8; c++) begin
      drive(c < 4, 8'(c + 1), 1'b1, 3'b000);
      ev = (c >= 3 && c <= 6);
      ed = ev ? 8'(c - 2) : 8'h13;
      n_checks++;
      if (out_valid !== ev || out_data !== ed) begin
        n_fail++; $display("FAIL stream_out c=%0d got v=%b d=%h exp v=%b d=%h", c, out_valid, out_data, ev, ed);
      end
      if (c == 3 || c == 4) begin
        n_checks++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL stream_occ c=%0d got %0d exp 3", c, occupancy); end
      end
      edge_step();
    end
  endtask

  task automatic test_backpressure();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'(8'h0A + c), 1'b0, 3'b000);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_fill_ready c=%0d got %b exp 1", c, in_ready); end
      edge_step();
    end
    drive(1'b1, 8'h0D, 1'b0, 3'b000);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b exp 0", in_ready); end
    n_checks++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL bp_full_occ got %0d exp 3", occupancy); end
    edge_step();
    drive(1'b1, 8'h0D, 1'b1, 3'b000);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h0A) begin n_fail++; $display("FAIL bp_drain k=0 got v=%b d=%h exp v=1 d=0a", out_valid, out_data); end
    edge_step();
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1, 3'b000);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h0A + k)) begin
        n_fail++; $display("FAIL bp_drain k=%0d got v=%b d=%h exp v=1 d=%h", k, out_valid, out_data, 8'(8'h0A + k));
      end
      edge_step();
    end
    drive(1'b0, 8'h00, 1'b1, 3'b000);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got v=%b exp 0", out_valid); end
  endtask

  task automatic test_bubble();
    drive(1'b1, 8'h05, 1'b0, 3'b000);
    edge_step();
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b0, 3'b000);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_ready k=%0d got %b exp 1", k, in_ready); end
      n_checks++; if (out_valid !== (k == 3)) begin n_fail++; $display("FAIL bubble_out_valid k=%0d got %b exp %b", k, out_valid, k == 3); end
      if (k == 3) begin
        n_checks++; if (out_data !== 8'h05) begin n_fail++; $display("FAIL bubble_data got %h exp 05", out_data); end
      end
      edge_step();
    end
    drive(1'b0, 8'h00, 1'b1, 3'b000);
    edge_step();
  endtask

  task automatic test_flush();
    logic [7:0] got[$];
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'(8'h23 - c), 1'b0, 3'b000);
      edge_step();
    end
    drive(1'b0, 8'h00, 1'b0, 3'b010);
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h23) begin n_fail++; $display("FAIL flush_mid_out got v=%b d=%h exp v=1 d=23", out_valid, out_data); end
    edge_step();
    drive(1'b0, 8'h00, 1'b0, 3'b000);
    n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_occ got %0d exp 2", occupancy); end
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 8'h00, 1'b1, 3'b000);
      if (out_valid === 1'b1) got.push_back(out_data);
      edge_step();
    end
    n_checks++;
    if (got.size() != 2 || got[0] !== 8'h23 || got[1] !== 8'h21) begin
      n_fail++; $display("FAIL flush_order got n=%0d %p exp 23,21", got.size(), got);
    end
  endtask

  task automatic test_out_flush();
    drive(1'b1, 8'h33, 1'b0, 3'b000);
    edge_step();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 8'h00, 1'b0, 3'b000);
      edge_step();
    end
    drive(1'b0, 8'h00, 1'b1, 3'b100);
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h33) begin n_fail++; $display("FAIL oflush_now got v=%b d=%h exp v=0 d=33", out_valid, out_data); end
    edge_step();
    drive(1'b0, 8'h00, 1'b1, 3'b000);
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h13) begin n_fail++; $display("FAIL oflush_after got v=%b d=%h exp v=0 d=13", out_valid, out_data); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL oflush_occ got %0d exp 0", occupancy); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'(8'h41 + c), 1'b0, 3'b000);
      edge_step();
    end
    drive(1'b0, 8'h00, 1'b0, 3'b000);
    n_checks++; if (occupancy !== 2'd3) begin n_fail++; $display("FAIL rstmid_full got %0d exp 3", occupancy); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h13) begin n_fail++; $display("FAIL rstmid_out got v=%b d=%h exp v=0 d=13", out_valid, out_data); end
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rstmid_occ got %0d exp 0", occupancy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", in_ready); end
    drive(1'b1, 8'h55, 1'b1, 3'b000);
    edge_step();
    n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rstmid_held got %0d exp 0", occupancy); end
    #2;
    rst = 1'b0;
    drive(1'b1, 8'h77, 1'b1, 3'b000);
    edge_step();
    for (int c = 1; c < 4; c++) begin
      drive(1'b0, 8'h00, 1'b1, 3'b000);
      n_checks++;
      if (out_valid !== (c == 3) || (c == 3 && out_data !== 8'h77)) begin
        n_fail++; $display("FAIL rstmid_latency c=%0d got v=%b d=%h exp v=%b d=77", c, out_valid, out_data, c == 3);
      end
      edge_step();
    end
  endtask

  // Reference: items occupy slots; each moves forward when the slot ahead frees up, flushed items vanish.
  task automatic test_random();
    logic       mv[3];
    logic [7:0] md[3];
    logic       nv[3];
    logic [7:0] nd[3];
    logic       v, r, space, exp_ov;
    logic [7:0] d, exp_od;
    logic [2:0] fm;
    int         cnt;
    #2; rst = 1'b1; #1; rst = 1'b0;
    edge_step();
    for (int i = 0; i < 3; i++) begin mv[i] = 1'b0; md[i] = 8'h00; end
    for (int n = 0; n < 1500; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      d  = 8'($urandom);
      r  = ($urandom_range(0, 2) != 0);
      fm = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      drive(v, d, r, fm);
      cnt = 0;
      for (int i = 0; i < 3; i++) cnt += int'(mv[i]);
      exp_ov = mv[2] & ~fm[2];
      exp_od = mv[2] ? md[2] : 8'h13;
      n_checks++; if (in_ready !== (cnt < 3 || r)) begin n_fail++; $display("FAIL rnd_ready n=%0d got %b exp %b", n, in_ready, (cnt < 3 || r)); end
      n_checks++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_out_valid n=%0d got %b exp %b", n, out_valid, exp_ov); end
      n_checks++; if (out_data !== exp_od) begin n_fail++; $display("FAIL rnd_out_data n=%0d got %h exp %h", n, out_data, exp_od); end
      n_checks++; if (occupancy !== 2'(cnt)) begin n_fail++; $display("FAIL rnd_occ n=%0d got %0d exp %0d", n, occupancy, cnt); end
      for (int i = 0; i < 3; i++) begin nv[i] = 1'b0; nd[i] = 8'h00; end
      space = r;
      for (int i = 2; i >= 0; i--) begin
        if (mv[i] && !fm[i]) begin
          if (!space) begin
            nv[i] = 1'b1; nd[i] = md[i];
          end else if (i < 2) begin
            nv[i+1] = 1'b1; nd[i+1] = md[i];
          end
        end
        space = space | ~mv[i];
      end
      if (v && space) begin nv[0] = 1'b1; nd[0] = d; end
      edge_step();
      mv = nv;
      md = nd;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; flush_mask = 3'b000;
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_flush();
    test_out_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_reg_chain.md
PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload bit width (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of register stages (>=1).
REQ-003 SHALL have parameter NOP_VALUE, default 32'h00000013, meaning the value driven on out_data when no valid item is presented, truncated/zero-extended to WIDTH.
REQ-004 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have in_valid  input  1  upstream item present.
REQ-007 SHALL have in_data  input  WIDTH  upstream payload.
REQ-008 SHALL have in_ready  output  1  stage 0 accepts this cycle.
REQ-009 SHALL have out_valid  output  1  last stage presents a live item.
REQ-010 SHALL have out_data  output  WIDTH  last-stage payload.
REQ-011 SHALL have out_ready  input  1  downstream accepts.
REQ-012 SHALL have flush_mask  input  DEPTH  bit i kills the item held in stage i (bit 0 is the stage nearest the input).
REQ-013 SHALL have occupancy  output  clog2(DEPTH+1)  count of valid stages, registered.

Function
REQ-014 Each stage i SHALL hold valid[i] and data[i]; the input handshake is in_valid&in_ready and the output handshake is out_valid&out_ready.
REQ-015 adv[DEPTH-1] SHALL be !valid[DEPTH-1] | out_ready, and adv[i] SHALL be !valid[i] | adv[i+1] for i<DEPTH-1 (bubble collapsing).
REQ-016 in_ready SHALL equal adv[0] and SHALL NOT depend combinationally on flush_mask or in_valid.
REQ-017 When adv[i] is high, stage i SHALL load valid/data from stage i-1 (or from in_valid/in_data for i=0); otherwise it SHALL hold.
REQ-018 An item whose stage bit is set in flush_mask SHALL NOT propagate: the incoming valid into stage i+1 SHALL be valid[i]&!flush_mask[i].
REQ-019 A stage with flush_mask[i]=1 and adv[i]=0 SHALL become invalid; one with adv[i]=1 SHALL still load its upstream item.
REQ-020 out_valid SHALL be valid[DEPTH-1]&!flush_mask[DEPTH-1].
REQ-021 out_data SHALL be data[DEPTH-1] when valid[DEPTH-1], else NOP_VALUE.
REQ-022 Data registers of invalid stages SHALL NOT be required to hold any particular value.
REQ-023 Unobstructed latency from input handshake to out_valid SHALL be exactly DEPTH cycles; throughput SHALL be one item per cycle with out_ready held high.
REQ-024 The chain SHALL hold DEPTH items when out_ready is low and never drop, duplicate or reorder unflushed items.
REQ-025 occupancy SHALL equal the number of set valid[] bits after each edge and SHALL saturate neither above DEPTH nor below 0.
REQ-026 Simultaneous input and output handshakes on a full chain SHALL keep occupancy at DEPTH.

Reset
REQ-027 While rst=1, all valid[] bits SHALL clear immediately (asynchronously) and occupancy SHALL be 0.
REQ-028 While rst=1, out_valid SHALL be 0, out_data SHALL be NOP_VALUE and in_ready SHALL be 1.
REQ-029 Items in flight when rst asserts SHALL be discarded, and no handshake SHALL complete while rst=1.
REQ-030 Data registers SHALL NOT require reset.

Structure
REQ-031 A shared package SHALL hold the clog2 helper constant function and the NOP_VALUE default constant (RV32 ADDI x0,x0,0).
REQ-032 One sub-module pipe_stage (valid+data register, adv/flush load logic) SHALL be instantiated DEPTH times via generate.

Verification (WIDTH=8, DEPTH=3, NOP_VALUE=8'h13)
REQ-033 Streaming: out_ready=1, in_data 01,02,03,04 on consecutive cycles -> out_data 01..04 on cycles 3..6 with out_valid=1, occupancy steady at 3.
REQ-034 Backpressure: out_ready=0, push 0A,0B,0C,0D -> 0A..0C accepted, in_ready=0 at 0D, occupancy=3; out_ready=1 -> 0A,0B,0C,0D drain in order, no gaps.
REQ-035 Bubble collapse: out_ready=0, stage0 holds 05, stages 1–2 empty -> 05 reaches stage 2 in 2 cycles and in_ready stays 1 throughout.
REQ-036 Flush: stages hold 21,22,23 (stage2=23), out_ready=0, flush_mask=3'b010 for one cycle -> next cycle valid=101, later output order 23,21, and 22 never appears.
REQ-037 Output flush: stage2 holds 33, flush_mask=3'b100, out_ready=1 -> out_valid=0 and out_data=33 is not consumed that cycle, then out_data=13.
REQ-038 Reset mid-operation: chain full, assert rst between clock edges -> out_valid=0, out_data=13, occupancy=0, in_ready=1 before the next edge; after release, first push appears after 3 cycles.
